// File: rtl/adder_arbiter_pkg.sv
// rtl/adder_arbiter_pkg.sv - shared types and constants for the adder arbiter
//
// Purpose : state encoding, operand width, excess-3 bias and event counter
//           width, plus the overflow rule shared by the adder.
// Ports   : none (package).

package adder_arbiter_pkg;

  // Operand and result width.
  localparam int W = 4;

  // Excess-3 bias added to every sum.
  localparam logic [W-1:0] E3_BIAS = W'(3);

  // Width of the optional completed-operation counters.
  localparam int CNT_W = 8;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Overflow is raised when both operands share a sign bit and the biased
  // sum's top bit differs from it.
  function automatic logic e3_overflow(input logic [W-1:0] a,
                                       input logic [W-1:0] b,
                                       input logic [W-1:0] s);
    return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
  endfunction

endpackage

// File: rtl/adder_arbiter_adder4.sv
// rtl/adder_arbiter_adder4.sv - 4-bit excess-3 biased adder (module adder4)
//
// Purpose : purely combinational; sum_e3 = (A + B + 3) mod 16 and the
//           matching overflow flag.
// Ports   : A        in  [3:0] first operand
//           B        in  [3:0] second operand
//           sum_e3   out [3:0] biased sum, wraps modulo 16
//           overflow out       sign-style overflow of the biased sum

module adder4
  import adder_arbiter_pkg::*;
(
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic [W-1:0] sum_e3,
  output logic         overflow
);

  // All three terms are W bits wide, so the carry out is simply dropped.
  assign sum_e3   = A + B + E3_BIAS;
  assign overflow = e3_overflow(A, B, sum_e3);

endmodule

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - two-requester round-robin arbiter around one adder4
//
// Purpose : arbitrates two requesters for a single excess-3 adder. A request
//           seen in IDLE latches the winner's operands, EXEC registers the
//           result, DONE pulses the owner's done for one cycle.
// Ports   : clk           in        single clock, rising edge
//           rst           in        synchronous active-high reset
//           req0, req1    in        requests, held until matching done
//           a0, b0        in  [3:0] operands of requester 0
//           a1, b1        in  [3:0] operands of requester 1
//           gnt0, gnt1    out       owner indication in EXEC and DONE
//           done0, done1  out       one-cycle result-valid pulse
//           sum_o         out [3:0] registered excess-3 sum
//           ovf_o         out       registered overflow flag
//           cnt0, cnt1    out [7:0] saturating completed-operation counts,
//                                   present only with ADDER_ARB_CNT_EN
// Config  : define ADDER_ARB_CNT_EN to add the cnt0/cnt1 counters.

module adder_arbiter
  import adder_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [W-1:0]     a0,
  input  logic [W-1:0]     b0,
  input  logic [W-1:0]     a1,
  input  logic [W-1:0]     b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [W-1:0]     sum_o,
`ifdef ADDER_ARB_CNT_EN
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
`endif
  output logic             ovf_o
);

  state_e         state_q;
  logic           ptr_q;     // favoured requester when both ask
  logic           owner_q;   // requester currently holding the adder
  logic [W-1:0]   op_a_q;
  logic [W-1:0]   op_b_q;
  logic           gnt0_q;
  logic           gnt1_q;
  logic           done0_q;
  logic           done1_q;
  logic [W-1:0]   sum_q;
  logic           ovf_q;

  logic           win_d;     // arbitration winner for the current IDLE cycle
  logic [W-1:0]   add_sum;
  logic           add_ovf;

  // A lone requester wins outright; the pointer only breaks ties.
  always_comb begin
    win_d = 1'b0;
    if (req0 && req1) begin
      win_d = ptr_q;
    end else if (req1) begin
      win_d = 1'b1;
    end
  end

  // The adder only ever sees the latched operands, so the requester may
  // change its a/b once the capture cycle has passed.
  adder4 u_adder4 (
    .A        (op_a_q),
    .B        (op_b_q),
    .sum_e3   (add_sum),
    .overflow (add_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          if (req0 || req1) begin
            owner_q <= win_d;
            op_a_q  <= win_d ? a1 : a0;
            op_b_q  <= win_d ? b1 : b0;
            gnt0_q  <= !win_d;
            gnt1_q  <= win_d;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          sum_q   <= add_sum;
          ovf_q   <= add_ovf;
          done0_q <= !owner_q;
          done1_q <= owner_q;
          // Hand priority to the other side as the result is delivered.
          ptr_q   <= !owner_q;
          state_q <= DONE;
        end
        DONE: begin
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign done0 = done0_q;
  assign done1 = done1_q;
  assign sum_o = sum_q;
  assign ovf_o = ovf_q;

`ifdef ADDER_ARB_CNT_EN
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  // Counts advance on the same edge that raises done, so the new value is
  // visible together with the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (state_q == EXEC) begin
      if (!owner_q && (cnt0_q != {CNT_W{1'b1}})) begin
        cnt0_q <= cnt0_q + CNT_W'(1);
      end
      if (owner_q && (cnt1_q != {CNT_W{1'b1}})) begin
        cnt1_q <= cnt1_q + CNT_W'(1);
      end
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - directed table-driven bench for adder_arbiter

module tb_adder_arbiter;

  logic       clk;
  logic       rst;
  logic       req0, req1;
  logic [3:0] a0, b0, a1, b1;
  logic       gnt0, gnt1, done0, done1;
  logic [3:0] sum_o;
  logic       ovf_o;
`ifdef ADDER_ARB_CNT_EN
  logic [7:0] cnt0, cnt1;
`endif

  int n_vec;
  int n_err;

  adder_arbiter dut (
    .clk   (clk),
    .rst   (rst),
    .req0  (req0),
    .req1  (req1),
    .a0    (a0),
    .b0    (b0),
    .a1    (a1),
    .b1    (b1),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .done0 (done0),
    .done1 (done1),
    .sum_o (sum_o),
`ifdef ADDER_ARB_CNT_EN
    .cnt0  (cnt0),
    .cnt1  (cnt1),
`endif
    .ovf_o (ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r0;
    logic       r1;
    logic [3:0] a0;
    logic [3:0] b0;
    logic [3:0] a1;
    logic [3:0] b1;
    logic       own;
    logic [3:0] s;
    logic       v;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_idle(input string tag, input logic [3:0] s, input logic v);
    chk({tag, " gnt0"},  32'(gnt0),  0);
    chk({tag, " gnt1"},  32'(gnt1),  0);
    chk({tag, " done0"}, 32'(done0), 0);
    chk({tag, " done1"}, 32'(done1), 0);
    chk({tag, " sum"},   32'(sum_o), 32'(s));
    chk({tag, " ovf"},   32'(ovf_o), 32'(v));
  endtask

  // Called at a negedge with the FSM in IDLE; returns at a negedge in IDLE.
  task automatic apply_vec(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    req0 = v.r0; req1 = v.r1;
    a0 = v.a0; b0 = v.b0; a1 = v.a1; b1 = v.b1;
    @(negedge clk);
    chk({t, " exec gnt0"}, 32'(gnt0), 32'(!v.own));
    chk({t, " exec gnt1"}, 32'(gnt1), 32'(v.own));
    chk({t, " exec done"}, 32'(done0 | done1), 0);
    @(negedge clk);
    chk({t, " done gnt0"},  32'(gnt0),  32'(!v.own));
    chk({t, " done gnt1"},  32'(gnt1),  32'(v.own));
    chk({t, " done0"},      32'(done0), 32'(!v.own));
    chk({t, " done1"},      32'(done1), 32'(v.own));
    chk({t, " sum"},        32'(sum_o), 32'(v.s));
    chk({t, " ovf"},        32'(ovf_o), 32'(v.v));
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk_idle({t, " idle"}, v.s, v.v);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;

    //           r0    r1    a0     b0     a1     b1     own   sum    ovf
    vecs[0] = '{1'b1, 1'b0, 4'd2,  4'd3,  4'd0,  4'd0,  1'b0, 4'd8,  1'b1};
    vecs[1] = '{1'b0, 1'b1, 4'd0,  4'd0,  4'd8,  4'd8,  1'b1, 4'd3,  1'b1};
    vecs[2] = '{1'b0, 1'b1, 4'd0,  4'd0,  4'd7,  4'd9,  1'b1, 4'd3,  1'b0};
    vecs[3] = '{1'b1, 1'b0, 4'd0,  4'd0,  4'd0,  4'd0,  1'b0, 4'd3,  1'b0};
    vecs[4] = '{1'b0, 1'b1, 4'd0,  4'd0,  4'd15, 4'd15, 1'b1, 4'd1,  1'b1};
    vecs[5] = '{1'b1, 1'b0, 4'd4,  4'd1,  4'd0,  4'd0,  1'b0, 4'd8,  1'b1};
    vecs[6] = '{1'b1, 1'b0, 4'd12, 4'd0,  4'd0,  4'd0,  1'b0, 4'd15, 1'b0};
    // Pointer now favours requester 1, then requester 0.
    vecs[7] = '{1'b1, 1'b1, 4'd1,  4'd1,  4'd5,  4'd6,  1'b1, 4'd14, 1'b1};
    vecs[8] = '{1'b1, 1'b1, 4'd6,  4'd6,  4'd1,  4'd1,  1'b0, 4'd15, 1'b1};
    // Pointer favours 1 but only requester 0 asks.
    vecs[9] = '{1'b1, 1'b0, 4'd3,  4'd4,  4'd0,  4'd0,  1'b0, 4'd10, 1'b1};

    do_reset();
    chk_idle("reset", 4'd0, 1'b0);
`ifdef ADDER_ARB_CNT_EN
    chk("reset cnt0", 32'(cnt0), 0);
    chk("reset cnt1", 32'(cnt1), 0);
`endif

    for (int i = 0; i < 10; i++) begin
      apply_vec(vecs[i], i);
    end

    // Both requests held from reset: served 0,1,0,1 with no overlap.
    begin
      int nd;
      nd = 0;
      do_reset();
      a0 = 4'd1; b0 = 4'd1; a1 = 4'd2; b1 = 4'd2;
      req0 = 1'b1; req1 = 1'b1;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        chk($sformatf("rr overlap c%0d", c), 32'(gnt0 & gnt1), 0);
        if (done0 || done1) begin
          if (nd < 4) begin
            chk($sformatf("rr owner %0d", nd), 32'(done1), nd % 2);
            chk($sformatf("rr sum %0d", nd), 32'(sum_o), (nd % 2) ? 7 : 5);
          end
          nd++;
        end
      end
      chk("rr done count", nd, 4);
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
    end

    // Reset while in EXEC discards the operation.
    begin
      bit seen;
      seen = 1'b0;
      a0 = 4'd9; b0 = 4'd9;
      req0 = 1'b1;
      @(negedge clk);
      chk("mid-rst exec gnt0", 32'(gnt0), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      req0 = 1'b0;
      chk_idle("mid-rst", 4'd0, 1'b0);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        if (done0 || done1 || gnt0 || gnt1) seen = 1'b1;
      end
      chk("mid-rst no pulse", 32'(seen), 0);
      apply_vec(vecs[0], 100);
    end

    // Operand change after capture has no effect.
    a0 = 4'd2; b0 = 4'd3;
    req0 = 1'b1;
    @(negedge clk);
    a0 = 4'd15;
    @(negedge clk);
    chk("stable done0", 32'(done0), 1);
    chk("stable sum", 32'(sum_o), 8);
    chk("stable ovf", 32'(ovf_o), 1);
    req0 = 1'b0;
    @(negedge clk);

`ifdef ADDER_ARB_CNT_EN
    do_reset();
    a0 = 4'd1; b0 = 4'd1;
    req0 = 1'b1;
    repeat (900) @(negedge clk);
    req0 = 1'b0;
    @(negedge clk);
    chk("sat cnt0", 32'(cnt0), 255);
    chk("sat cnt1", 32'(cnt1), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 The block SHALL have no parameters; operand and result width SHALL be fixed at 4 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0, req1  input  1 each  request from requester 0/1; held high with operands stable until matching done pulse.
REQ-005 a0, b0, a1, b1  input  4 each  operands of requester 0/1.
REQ-006 gnt0, gnt1  output  1 each  requester owns the adder.
REQ-007 done0, done1  output  1 each  one-cycle pulse: result for that requester valid.
REQ-008 sum_o  output  4  registered excess-3 sum of granted operands.
REQ-009 ovf_o  output  1  registered overflow flag of that sum.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, EXEC, DONE.
REQ-011 IDLE: if any req is high, the block SHALL pick a winner, latch its a/b into internal operand registers, record the owner and go to EXEC; otherwise stay in IDLE.
REQ-012 Arbitration SHALL be round-robin with a 1-bit pointer: both requesting -> the pointer's side wins; one requesting -> it wins regardless of pointer.
REQ-013 The pointer SHALL move to the non-served requester on entry to DONE.
REQ-014 EXEC: the block SHALL register sum_o and ovf_o from the latched operands and go to DONE.
REQ-015 DONE: the block SHALL assert done of the owner for exactly one cycle, then return to IDLE.
REQ-016 gntN SHALL be high in EXEC and DONE when N is owner, low otherwise; at most one gnt high at a time.
REQ-017 Latency: req sampled in IDLE at cycle N -> gnt high in cycles N+1..N+2; done and new sum_o/ovf_o visible in cycle N+2.
REQ-018 Arithmetic: sum_o = (A + B + 3) mod 16.
REQ-019 ovf_o SHALL be 1 iff A[3] == B[3] and sum_o[3] != A[3].
REQ-020 sum_o and ovf_o SHALL hold their last value until the next EXEC.
REQ-021 Operand changes on a/b after the IDLE capture cycle SHALL NOT affect the result.
REQ-022 A req still high in IDLE after done SHALL be treated as a new request.
REQ-023 Requests dropped before grant SHALL be ignored; no state is kept for them.

Reset
REQ-024 rst SHALL take priority over all other activity in any state, including mid-EXEC or DONE.
REQ-025 On reset: state=IDLE, pointer=0 (requester 0 favoured), gnt0/1=0, done0/1=0, sum_o=0, ovf_o=0.
REQ-026 On reset, any in-flight operation SHALL be discarded with no done pulse.

Configuration
REQ-027 Macro ADDER_ARB_CNT_EN, when defined, SHALL add outputs cnt0 and cnt1 (8 bits each).
REQ-028 cnt0/cnt1 SHALL count completed operations per requester, incrementing in the done cycle and saturating at 255.
REQ-029 cnt0/cnt1 SHALL reset to 0.
REQ-030 Without ADDER_ARB_CNT_EN, these ports and their counters SHALL NOT exist; all other behaviour is identical.

Structure
REQ-031 A shared package SHALL hold the state encoding (IDLE/EXEC/DONE), the width constant 4, the excess-3 bias constant 3, and the counter width 8.
REQ-032 The existing adder4 module (ports A, B, sum_e3, overflow) SHALL be instantiated once as the only sub-module, fed from the latched operand registers.

Verification
REQ-033 Single request: req0, a0=2, b0=3 -> gnt0 for 2 cycles; done0 on 2nd cycle; sum_o=8, ovf_o=1.
REQ-034 Wrap-around: req1, a1=8, b1=8 -> sum_o=3, ovf_o=1; then a1=7, b1=9 -> sum_o=3, ovf_o=0.
REQ-035 Simultaneous requests after reset with both req held: req0 (1+1 -> sum 5) served first, then req1. Grants alternate 0,1,0,1; gnt never overlaps.
REQ-036 Reset mid-operation: assert rst in EXEC -> next cycle IDLE, all outputs 0, no done pulse; a following request completes normally.
REQ-037 Operand stability: change a0 from 2 to 15 during EXEC -> result still reflects a0=2.
REQ-038 With ADDER_ARB_CNT_EN: 300 back-to-back req0 operations -> cnt0=255 (saturated), cnt1=0.
